uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Bus-mapped UART receiver, 8N1, LSB first. It consumes the serial stream produced by the UART transmitter.
//  Sits on the CPU mem_* bus beside the transmitter and shares its enable/tri-state decode convention.
//  Received bytes are buffered and read by the CPU; overrun and framing errors are reported as sticky flags.
// PARAMETERS
//  BAUD_DIVIDER  1301  bit period = BAUD_DIVIDER+1 clk cycles; must match the transmitter
//  FIFO_DEPTH    16    receive FIFO depth, power of 2, >=2; used only with UART_RX_FIFO_EN
// PORTS
//  clk        in   1   system clock
//  resetn     in   1   asynchronous active-low reset
//  enable     in   1   address decode select; bus outputs are 'bz when low
//  mem_valid  in   1   bus request
//  mem_ready  out  1   bus acknowledge (tri-stated)
//  mem_instr  in   1   ignored
//  mem_wstrb  in   4   nonzero = write; writes are acked and ignored
//  mem_wdata  in   32  ignored
//  mem_addr   in   32  bit[2]: 0=DATA, 1=STATUS
//  mem_rdata  out  32  read data (tri-stated)
//  serialIn   in   1   async serial line, idle high
//  rxIrq      out  1   high while the buffer is non-empty
// BEHAVIOUR
//  Reset (async): state=IDLE; buffer empty; flags clear; synchronizer=1,1; rdy=0; rdata=0; rxIrq=0.
//  serialIn passes through a 2-flop synchronizer (rxs); every decision uses rxs.
//  FSM, bit timer 0..BAUD_DIVIDER:
//   IDLE : rxs==0 -> START, timer=0.
//   START: timer==BAUD_DIVIDER/2: rxs==0 -> DATA, timer=0, bitCount=8; else -> IDLE (glitch, no flag).
//   DATA : timer==BAUD_DIVIDER: shift rxs into bit7 (LSB arrives first), bitCount-1, timer=0;
//          after 8th bit -> STOP.
//   STOP : timer==BAUD_DIVIDER: rxs==1 -> push byte, -> IDLE; rxs==0 -> set FERR, discard byte, -> BREAK.
//   BREAK: wait for rxs==1 -> IDLE.
//  Push when full: byte dropped, OVR set; buffer contents unchanged.
//  Bus: rdy <= mem_valid&enable (same registered handshake as the transmitter).
//   Side effects fire once per access, on the cycle mem_valid&enable&!rdy.
//   rdata is registered on that cycle. mem_ready/mem_rdata = enable ? rdy/rdata : 'bz.
//   DATA read : {24'b0, head byte}; pops one entry. If empty, returns 0 and does not pop.
//   STATUS read: bit0=AVAIL, bit1=OVR, bit2=FERR, bits[15:8]=fill count, rest 0.
//                Clears OVR and FERR after sampling; a set from the same cycle wins.
//   Write: acked, no effect.
//  Simultaneous pop and push in one cycle, including when full: both succeed, no OVR.
//  Latency: byte is visible in STATUS and rxIrq 1 clk after the STOP sample cycle.
//  rxIrq = registered (count!=0).
// CONFIGURATION
//  UART_RX_FIFO_EN defined: FIFO_DEPTH-entry circular FIFO; pointers wrap modulo FIFO_DEPTH.
//  Undefined: single holding register (depth 1); a second byte pushed before the read sets OVR.
//  Fill count field saturates at 1. Bus map and flags are identical in both cases.
// STRUCTURE
//  uart_pkg: FSM state encoding (IDLE, START, DATA, STOP, BREAK), DATA/STATUS offsets,
//   STATUS bit positions.
//  Sub-module uart_rx_fifo(clk, resetn, push, din, pop, dout, count, full, empty).
//   Holds the buffer, with the depth-1 variant under the macro.
//   Top level holds the synchronizer, FSM, flags and bus logic.
// TESTING (BAUD_DIVIDER=9, FIFO_DEPTH=4 unless stated)
//  1 Frame 0x55 -> rxIrq=1, STATUS=0x0101; DATA read=0x55; then STATUS=0x0000, rxIrq=0.
//  2 serialIn low 3 clks, then high -> no byte, no flags, FSM back in IDLE.
//  3 Frame 0xA5 with stop bit=0 -> STATUS=0x0004, no byte; second STATUS read=0x0000.
//  4 Send 5 bytes 0x01..0x05 unread -> STATUS=0x0403 (count 4, OVR, AVAIL); reads return 0x01..0x04.
//    Without the macro: 2 bytes -> OVR set, DATA read=0x01.
//  5 Buffer full; DATA read lands on the same cycle as a stop-bit push -> no OVR, count stays 4, order kept.
//  6 resetn pulsed mid-DATA of a frame -> all outputs at reset values; next full frame 0x3C received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, register map and STATUS layout.
// The receive FIFO depth is selected by the UART_RX_FIFO_EN macro (see uart_rx_fifo).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int  ADDR_SEL_BIT = 2;
    localparam logic REG_DATA    = 1'b0;
    localparam logic REG_STATUS  = 1'b1;

    localparam int STAT_AVAIL   = 0;
    localparam int STAT_OVR     = 1;
    localparam int STAT_FERR    = 2;
    localparam int STAT_CNT_LSB = 8;

    // The STATUS fill field is only 8 bits wide; deeper buffers clamp at 255.
    function automatic logic [7:0] sat_fill(input logic [15:0] cnt);
        return (cnt > 16'd255) ? 8'hFF : cnt[7:0];
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer for uart_rx. With UART_RX_FIFO_EN defined it is a FIFO_DEPTH-entry
// circular FIFO; otherwise it is a single holding register.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic do_pop;
    logic do_push;

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in, even when full.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
`else
    logic [7:0] hold;
    logic       valid;

    assign empty   = ~valid;
    assign full    = valid;
    assign do_pop  = pop & valid;
    assign do_push = push & (~valid | do_pop);
    assign dout    = hold;
    assign count   = CNT_W'(valid);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
        end else if (do_push) begin
            valid <= 1'b1;
        end else if (do_pop) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) hold <= din;
    end
`endif

endmodule

// File: rtl/uart_rx.sv
// Bus-mapped 8N1 UART receiver with sticky overrun/framing flags.
// Buffer depth: FIFO_DEPTH entries when UART_RX_FIFO_EN is defined, otherwise one byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIVIDER = 1301,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic        serialIn,
    output logic        rxIrq
);

    localparam int TMR_W = $clog2(BAUD_DIVIDER + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TMR_W-1:0] T_FULL = TMR_W'(BAUD_DIVIDER);
    localparam logic [TMR_W-1:0] T_HALF = TMR_W'(BAUD_DIVIDER / 2);

    logic             rxs_meta;
    logic             rxs;
    rx_state_t        state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             push_req;
    logic             ferr_set;

    logic             rdy;
    logic [31:0]      rdata;
    logic             ovr;
    logic             ferr;
    logic             irq;

    logic             access;
    logic             rd_access;
    logic             stat_rd;
    logic             pop;
    logic             ovr_set;
    logic             accepted_push;
    logic             irq_nxt;
    logic [31:0]      status_word;

    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    logic             unused_ok;
    assign unused_ok = &{1'b0, mem_instr, mem_wdata, mem_addr[31:3], mem_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxs_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxs_meta <= serialIn;
            rxs      <= rxs_meta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_nxt;
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer + TMR_W'(1);
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        push_req    = 1'b0;
        ferr_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                if (!rxs) state_nxt = ST_START;
            end
            ST_START: begin
                // Re-check the line mid start bit to reject glitches.
                if (timer == T_HALF) begin
                    timer_nxt = '0;
                    if (!rxs) begin
                        state_nxt   = ST_DATA;
                        bit_cnt_nxt = 4'd8;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (timer == T_FULL) begin
                    timer_nxt   = '0;
                    shift_nxt   = {rxs, shift[7:1]};
                    bit_cnt_nxt = bit_cnt - 4'd1;
                    if (bit_cnt == 4'd1) state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (timer == T_FULL) begin
                    timer_nxt = '0;
                    if (rxs) begin
                        push_req  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                timer_nxt = '0;
                if (rxs) state_nxt = ST_IDLE;
            end
            default: begin
                timer_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_req),
        .din    (shift),
        .pop    (pop),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign access    = mem_valid & enable & ~rdy;
    assign rd_access = access & (mem_wstrb == 4'b0000);
    assign stat_rd   = rd_access & (mem_addr[ADDR_SEL_BIT] == REG_STATUS);
    assign pop       = rd_access & (mem_addr[ADDR_SEL_BIT] == REG_DATA) & ~fifo_empty;
    assign ovr_set   = push_req & fifo_full & ~pop;

    // Track the buffer's next occupancy so rxIrq rises together with the STATUS count.
    assign accepted_push = push_req & (~fifo_full | pop);
    assign irq_nxt = accepted_push | (fifo_count > CNT_W'(1)) | (~fifo_empty & ~pop);

    always_comb begin
        status_word = '0;
        status_word[STAT_AVAIL] = ~fifo_empty;
        status_word[STAT_OVR]   = ovr;
        status_word[STAT_FERR]  = ferr;
        status_word[STAT_CNT_LSB +: 8] = sat_fill(16'(fifo_count));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy   <= 1'b0;
            rdata <= '0;
            ovr   <= 1'b0;
            ferr  <= 1'b0;
            irq   <= 1'b0;
        end else begin
            rdy  <= mem_valid & enable;
            // A flag set in the same cycle as a STATUS read survives the clear.
            ovr  <= ovr_set  | (ovr  & ~stat_rd);
            ferr <= ferr_set | (ferr & ~stat_rd);
            irq  <= irq_nxt;
            if (access) begin
                if (!rd_access)
                    rdata <= '0;
                else if (stat_rd)
                    rdata <= status_word;
                else
                    rdata <= {24'b0, fifo_empty ? 8'h00 : fifo_dout};
            end
        end
    end

    assign mem_ready = enable ? rdy   : 1'bz;
    assign mem_rdata = enable ? rdata : 32'bz;
    assign rxIrq     = irq;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with BAUD_DIVIDER=9 (10 clk bit period) and FIFO_DEPTH=4.
// Expectations follow the UART_RX_FIFO_EN setting the bench is compiled with.
module tb_uart_rx;

    localparam int BAUD = 9;
`ifdef UART_RX_FIFO_EN
    localparam int TB_DEPTH = 4;
`else
    localparam int TB_DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        mem_valid;
    wire         mem_ready;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    wire  [31:0] mem_rdata;
    logic        serialIn;
    wire         rxIrq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx #(.BAUD_DIVIDER(BAUD), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_instr (mem_instr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .serialIn  (serialIn),
        .rxIrq     (rxIrq)
    );

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic        irq;
        logic [31:0] st1;
        logic [31:0] dat;
        logic [31:0] st2;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller must be at a negedge; returns at a negedge with the line idle.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        serialIn = 1'b0;
        repeat (BAUD + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            repeat (BAUD + 1) @(negedge clk);
        end
        serialIn = stop;
        repeat (BAUD + 1) @(negedge clk);
        serialIn = 1'b1;
    endtask

    task automatic bus_access(input logic is_status, input logic [3:0] wstrb,
                              output logic [31:0] rd, output logic ack);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = is_status ? 32'h4 : 32'h0;
        mem_wstrb = wstrb;
        mem_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        rd  = mem_rdata;
        ack = mem_ready;
        @(negedge clk);
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        @(negedge clk);
    endtask

    task automatic read_chk(input logic is_status, input string name, input logic [31:0] exp);
        logic [31:0] rd;
        logic        ack;
        bus_access(is_status, 4'b0000, rd, ack);
        check(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ack;

        vecs[0] = '{8'h55, 1'b1, 1'b1, 32'h0000_0101, 32'h0000_0055, 32'h0};
        vecs[1] = '{8'hA5, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 32'h0000_0101, 32'h0000_0000, 32'h0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 32'h0000_0101, 32'h0000_00FF, 32'h0};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 32'h0000_0101, 32'h0000_0081, 32'h0};

        resetn    = 1'b0;
        enable    = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_wstrb = 4'b0000;
        mem_wdata = 32'h0;
        mem_addr  = 32'h0;
        serialIn  = 1'b1;
        #12;
        check("reset_irq",   32'(rxIrq),     32'h0);
        check("reset_ready", 32'(mem_ready), 32'h0);
        check("reset_rdata", mem_rdata,      32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        read_chk(1'b1, "idle_status", 32'h0);

        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].data, vecs[v].stop);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_irq", v), 32'(rxIrq), 32'(vecs[v].irq));
            read_chk(1'b1, $sformatf("vec%0d_status", v), vecs[v].st1);
            read_chk(1'b0, $sformatf("vec%0d_data", v), vecs[v].dat);
            read_chk(1'b1, $sformatf("vec%0d_status2", v), vecs[v].st2);
            check($sformatf("vec%0d_irq_after", v), 32'(rxIrq), 32'h0);
        end

        // Short low glitch must not start a frame.
        @(negedge clk);
        serialIn = 1'b0;
        repeat (3) @(negedge clk);
        serialIn = 1'b1;
        repeat (20) @(negedge clk);
        read_chk(1'b1, "glitch_status", 32'h0);
        check("glitch_irq", 32'(rxIrq), 32'h0);
        send_frame(8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        bus_access(1'b0, 4'hF, rd, ack);
        check("write_ack", 32'(ack), 32'h1);
        read_chk(1'b1, "after_write_status", 32'h0000_0101);
        read_chk(1'b0, "glitch_next_data", 32'h0000_005A);

        // Overrun.
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (3) @(negedge clk);
        read_chk(1'b1, "ovr_status", 32'h0000_0403);
        for (int i = 1; i <= 4; i++) read_chk(1'b0, $sformatf("ovr_data%0d", i), 32'(i));
        read_chk(1'b1, "ovr_status2", 32'h0);
`else
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        repeat (3) @(negedge clk);
        read_chk(1'b1, "ovr_status", 32'h0000_0103);
        read_chk(1'b0, "ovr_data1", 32'h0000_0001);
        read_chk(1'b1, "ovr_status2", 32'h0);
`endif

        // Full buffer: DATA read on the exact cycle of the stop-bit push.
        for (int i = 0; i < TB_DEPTH; i++) send_frame(8'h11 + 8'(i), 1'b1);
        repeat (3) @(negedge clk);
        read_chk(1'b1, "full_status", 32'(TB_DEPTH * 256 + 1));
        @(negedge clk);
        fork
            send_frame(8'h11 + 8'(TB_DEPTH), 1'b1);
            begin
                repeat (97) @(posedge clk);
                @(negedge clk);
                mem_valid = 1'b1;
                mem_addr  = 32'h0;
                mem_wstrb = 4'b0000;
                @(posedge clk);
                #1;
                rd = mem_rdata;
                @(negedge clk);
                mem_valid = 1'b0;
            end
        join
        check("simul_pop_data", rd, 32'h0000_0011);
        repeat (3) @(negedge clk);
        read_chk(1'b1, "simul_status", 32'(TB_DEPTH * 256 + 1));
        for (int i = 1; i <= TB_DEPTH; i++)
            read_chk(1'b0, $sformatf("simul_order%0d", i), 32'h11 + 32'(i));
        read_chk(1'b1, "simul_status2", 32'h0);

        // Reset in the middle of a frame, with a byte already buffered.
        send_frame(8'h77, 1'b1);
        repeat (3) @(negedge clk);
        check("pre_reset_irq", 32'(rxIrq), 32'h1);
        @(negedge clk);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (40) @(posedge clk);
                #2 resetn = 1'b0;
                #1;
                check("midrst_irq",   32'(rxIrq),     32'h0);
                check("midrst_ready", 32'(mem_ready), 32'h0);
                check("midrst_rdata", mem_rdata,      32'h0);
                #20 resetn = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        read_chk(1'b1, "post_reset_status", 32'h0);
        send_frame(8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        read_chk(1'b1, "post_reset_frame_status", 32'h0000_0101);
        read_chk(1'b0, "post_reset_frame_data", 32'h0000_003C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
